// File: rtl/mem_bridge.sv
// Core-to-bus memory bridge: splits sized byte accesses into one or two
// word-aligned beats with byte enables, and aligns/extends returned load data.
module mem_bridge #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [29:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ0 = 3'd1,
    S_RD0  = 3'd2,
    S_REQ1 = 3'd3,
    S_RD1  = 3'd4
  } state_t;

  function automatic logic [3:0] f_mask(input logic [2:0] size);
    case (size)
      3'd0, 3'd4: f_mask = 4'b0001;
      3'd1, 3'd5: f_mask = 4'b0011;
      3'd2:       f_mask = 4'b1111;
      default:    f_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic f_illegal(input logic [2:0] size);
    f_illegal = (size == 3'd3) || (size == 3'd6) || (size == 3'd7);
  endfunction

  function automatic logic f_misaligned(input logic [2:0] size, input logic [1:0] off);
    case (size)
      3'd1, 3'd5: f_misaligned = off[0];
      3'd2:       f_misaligned = (off != 2'd0);
      default:    f_misaligned = 1'b0;
    endcase
  endfunction

  state_t      r_state;
  logic        r_req_ready;
  logic [31:0] r_addr;
  logic [2:0]  r_size;
  logic        r_we;
  logic [3:0]  r_be_hi;
  logic [31:0] r_wd_hi;
  logic [31:0] r_lo;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;
  logic        r_bus_valid;
  logic [29:0] r_bus_addr;
  logic        r_bus_we;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;

  logic [3:0]  w_mask;
  logic [7:0]  w_be8;
  logic [63:0] w_wd64;
  logic        w_reject;
  logic        w_two;
  logic [31:0] w_lo;
  logic [31:0] w_hi;
  logic [31:0] w_raw;
  logic [31:0] w_load;

  // Decode of the incoming request: lane mask, shifted enables/data, reject.
  always_comb begin
    w_mask   = f_mask(req_size);
    w_be8    = {4'b0000, w_mask} << req_addr[1:0];
    w_wd64   = {req_wdata, req_wdata} << {req_addr[1:0], 3'b000};
    w_reject = f_illegal(req_size) ||
               (!ALLOW_MISALIGNED && f_misaligned(req_size, req_addr[1:0]));
    w_two    = (r_be_hi != 4'b0000);
  end

  // Load alignment: the final beat's word comes straight from the bus.
  always_comb begin
    w_lo = r_lo;
    w_hi = 32'd0;
    if (r_state == S_RD0) begin
      w_lo = bus_rdata;
    end else if (r_state == S_RD1) begin
      w_hi = bus_rdata;
    end else begin
      w_hi = 32'd0;
    end
    w_raw = 32'({w_hi, w_lo} >> {r_addr[1:0], 3'b000});
    case (r_size)
      3'd0:    w_load = {{24{w_raw[7]}}, w_raw[7:0]};
      3'd4:    w_load = {24'd0, w_raw[7:0]};
      3'd1:    w_load = {{16{w_raw[15]}}, w_raw[15:0]};
      3'd5:    w_load = {16'd0, w_raw[15:0]};
      default: w_load = w_raw;
    endcase
  end

  // Request/beat sequencing FSM with registered bus and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_addr      <= 32'd0;
      r_size      <= 3'd0;
      r_we        <= 1'b0;
      r_be_hi     <= 4'd0;
      r_wd_hi     <= 32'd0;
      r_lo        <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_bus_valid <= 1'b0;
      r_bus_addr  <= 30'd0;
      r_bus_we    <= 1'b0;
      r_bus_be    <= 4'd0;
      r_bus_wdata <= 32'd0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_addr  <= req_addr;
            r_size  <= req_size;
            r_we    <= req_we;
            r_be_hi <= w_be8[7:4];
            r_wd_hi <= w_wd64[63:32];
            if (w_reject) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else begin
              r_state     <= S_REQ0;
              r_req_ready <= 1'b0;
              r_bus_valid <= 1'b1;
              r_bus_addr  <= req_addr[31:2];
              r_bus_we    <= req_we;
              r_bus_be    <= w_be8[3:0];
              r_bus_wdata <= w_wd64[31:0];
            end
          end
        end
        S_REQ0: begin
          if (bus_ready) begin
            if (r_we && w_two) begin
              r_state     <= S_REQ1;
              r_bus_addr  <= r_addr[31:2] + 30'd1;
              r_bus_be    <= r_be_hi;
              r_bus_wdata <= r_wd_hi;
            end else begin
              r_bus_valid <= 1'b0;
              r_bus_addr  <= 30'd0;
              r_bus_we    <= 1'b0;
              r_bus_be    <= 4'd0;
              r_bus_wdata <= 32'd0;
              if (r_we) begin
                r_state     <= S_IDLE;
                r_req_ready <= 1'b1;
                r_rsp_valid <= 1'b1;
              end else begin
                r_state <= S_RD0;
              end
            end
          end
        end
        S_RD0: begin
          if (bus_rvalid) begin
            r_lo <= bus_rdata;
            if (w_two) begin
              r_state     <= S_REQ1;
              r_bus_valid <= 1'b1;
              r_bus_addr  <= r_addr[31:2] + 30'd1;
              r_bus_we    <= 1'b0;
              r_bus_be    <= r_be_hi;
              r_bus_wdata <= 32'd0;
            end else begin
              r_state     <= S_IDLE;
              r_req_ready <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_load;
            end
          end
        end
        S_REQ1: begin
          if (bus_ready) begin
            r_bus_valid <= 1'b0;
            r_bus_addr  <= 30'd0;
            r_bus_we    <= 1'b0;
            r_bus_be    <= 4'd0;
            r_bus_wdata <= 32'd0;
            if (r_we) begin
              r_state     <= S_IDLE;
              r_req_ready <= 1'b1;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= S_RD1;
            end
          end
        end
        S_RD1: begin
          if (bus_rvalid) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_load;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_bus_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign bus_valid = r_bus_valid;
  assign bus_addr  = r_bus_addr;
  assign bus_we    = r_bus_we;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

endmodule
